// File: rtl/cfsr_prpg_if.sv
// Control and pattern bus between the BIST controller and the pattern generator.
interface cfsr_prpg_if #(
    parameter int unsigned WIDTH = 4
);
    logic             mode;
    logic             start;
    logic             abort;
    logic             en;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] pattern_out;
    logic             pattern_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] state_out;

    modport master (
        output mode, start, abort, en, seed_in,
        input  pattern_out, pattern_valid, busy, done, state_out
    );

    modport slave (
        input  mode, start, abort, en, seed_in,
        output pattern_out, pattern_valid, busy, done, state_out
    );
endinterface

// File: rtl/cfsr_prpg.sv
// BIST pattern generator: Fibonacci LFSR / complete-feedback shift register with
// seed loading, a pattern-count-bounded session FSM and optional output reorder.
module cfsr_prpg #(
    parameter int unsigned      WIDTH         = 4,
    parameter logic [WIDTH-1:0] TAPS          = WIDTH'(4'b1001),
    parameter logic [WIDTH-1:0] SEED          = WIDTH'(1),
    parameter int unsigned      PATTERN_COUNT = 16,
    parameter bit               REORDER_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    cfsr_prpg_if.slave  bus
);
    localparam int unsigned CW = $clog2(PATTERN_COUNT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] seed_eff_c;

    // Complete-feedback mode injects NOR of the low bits so all-zero joins the cycle.
    function automatic logic [WIDTH-1:0] next_sr(input logic [WIDTH-1:0] s, input logic m);
        logic fb;
        fb = ^(s & TAPS);
        if (m) fb = fb ^ ~(|s[WIDTH-2:0]);
        return {s[WIDTH-2:0], fb};
    endfunction

    function automatic logic [WIDTH-1:0] reorder(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        if (REORDER_EN && !s[WIDTH-1]) begin
            r[0] = s[1];
            r[1] = s[0];
        end
        return r;
    endfunction

    // An all-zero seed would lock a plain LFSR, so substitute the reset seed.
    always_comb begin
        seed_eff_c = bus.seed_in;
        if (!bus.mode && (bus.seed_in == '0)) seed_eff_c = SEED;
    end

    always_comb begin
        fsm_d   = fsm_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        valid_d = 1'b0;
        if (bus.abort) begin
            fsm_d = IDLE;
        end else begin
            unique case (fsm_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sr_d  = seed_eff_c;
                        cnt_d = '0;
                        fsm_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        pat_d   = reorder(sr_q);
                        valid_d = 1'b1;
                        sr_d    = next_sr(sr_q, bus.mode);
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) fsm_d = DONE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
        busy_d = (fsm_d == RUN);
        done_d = (fsm_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            sr_q    <= SEED;
            cnt_q   <= '0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pattern_out   = pat_q;
    assign bus.pattern_valid = valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.state_out     = sr_q;
endmodule

// File: doc/cfsr_prpg.md
Name: cfsr_prpg

Overview:
- Parametrised pseudo-random pattern generator for the BIST architecture.
- Runs a WIDTH-bit Fibonacci shift register in one of two modes:
  - plain LFSR mode, period 2^WIDTH-1;
  - complete feedback (CFSR / de Bruijn) mode, period 2^WIDTH, which includes all-zero.
- Adds seed loading, a pattern-count-bounded test session FSM with start/abort/done, an advance enable, and an optional registered output bit reorder.
- Drives the CUT pattern bus for the BIST controller.

Parameters:
- WIDTH, 4, register width (legal 3..32).
- TAPS, 4'b1001, WIDTH-bit feedback tap mask; bit i set means state[i] enters the feedback XOR. Must be primitive for maximal period.
- SEED, 1, WIDTH-bit reset value; also the LFSR-mode substitute for an all-zero seed.
- PATTERN_COUNT, 16, patterns issued per session (>=1).
- REORDER_EN, 1, enables the output reorder.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = LFSR, 1 = complete (CFSR).
- start  in  1  session start pulse.
- abort  in  1  session abort.
- en  in  1  advance enable while running.
- seed_in  in  WIDTH  seed captured on accepted start.
- pattern_out  out  WIDTH  registered test pattern.
- pattern_valid  out  1  pattern_out holds a new pattern this cycle.
- busy  out  1  FSM in RUN.
- done  out  1  session complete, sticky.
- state_out  out  WIDTH  raw shift register contents, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=SEED, count=0, FSM=IDLE;
  - pattern_out=0, pattern_valid=0, busy=0, done=0.
- Next-state function, with s=state and fb = XOR of s[i] over TAPS[i]=1:
  - If mode=1: fb ^= NOR(s[WIDTH-2:0]).
  - next = {s[WIDTH-2:0], fb}, i.e. shift toward MSB with feedback into bit 0.
- Reorder: if REORDER_EN=1 and s[WIDTH-1]=0, bits 0 and 1 are exchanged; otherwise the pattern equals s.
- Count register width is $clog2(PATTERN_COUNT+1).
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 -> state<=seed_eff, count<=0, go to RUN.
  - seed_eff = seed_in, except mode=0 with seed_in=0, where seed_eff = SEED (prevents LFSR lockup).
- RUN, en=1:
  - pattern_out<=reorder(state), pattern_valid<=1, state<=next(state), count<=count+1.
  - Output latency: one cycle from the state value; the first pattern issued is seed_eff.
  - When count==PATTERN_COUNT-1 on an advance, go to DONE next cycle.
- RUN, en=0: state, count and pattern_out hold; pattern_valid<=0.
- start in RUN is ignored.
- mode changes in RUN take effect on the next advance.
- DONE:
  - done=1, pattern_valid=0, state holds.
  - start=1 restarts exactly as from IDLE (done<=0, new seed).
- abort=1 in any state:
  - FSM->IDLE, busy<=0, done<=0, pattern_valid<=0.
  - state and pattern_out hold.
  - abort has priority over start in the same cycle.
- busy=1 exactly while FSM=RUN.
- Wrap-around: the sequence is periodic; PATTERN_COUNT larger than the period simply repeats the sequence.
- Reset mid-session returns immediately to reset values; no pattern_valid is issued after reset deassertion until a new start.

Test Plan:
- WIDTH=4, TAPS=1001, mode=1, seed 0001, PATTERN_COUNT=16, en=1, REORDER_EN=0:
  - pattern_out must be 0001,0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000,0000;
  - then done=1 and busy=0.
- Same run with REORDER_EN=1:
  - patterns with MSB 0 must have bits 0 and 1 swapped: 0001->0010, 0011->0011, 0110->0101, 0010->0001, 0000->0000;
  - patterns with MSB 1 pass unchanged.
- mode=0, seed_in=0000, PATTERN_COUNT=16:
  - seed replaced by 0001;
  - sequence 0001,0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000 repeats with period 15, so the 16th pattern is 0001;
  - 0000 never appears.
- en toggled 1,0,0,1 during RUN:
  - pattern_valid follows the 1,0,0,1 pattern delayed one cycle;
  - state and count frozen on en=0 cycles;
  - the total number of valid patterns still equals PATTERN_COUNT.
- start and abort asserted together in RUN after 5 patterns:
  - FSM goes to IDLE, busy=0, done=0;
  - a later start with seed 0001 restarts at 0001.
- rst_n pulsed low asynchronously mid-RUN (between clock edges):
  - all outputs reach reset values immediately: state_out=SEED, pattern_out=0, pattern_valid=0, done=0.
